// File: rtl/input_capture_arbiter_if.sv
// Handshake bundle between the two operand sources, the shared capture
// register and its consumer.
//   a_*   : source A (pin group)   valid/data in, ready out
//   b_*   : source B (port group)  valid/data in, ready out
//   out_* : captured payload, source id and consumer ready
// slave  : arbiter side, master : sources/consumer side.
interface input_capture_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_src
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/input_capture_arbiter.sv
// Burst-limited round-robin arbiter feeding one registered capture stage.
// Ports:
//   clk_i         : clock, all state on posedge
//   rst_ni        : synchronous active-low reset
//   bus           : A/B request handshakes and output register (slave side)
//   stat_clr_i    : synchronous clear of both grant counters
//   grant_cnt_a_o : saturating count of A grants
//   grant_cnt_b_o : saturating count of B grants
module input_capture_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 2,
  parameter int CNT_W     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input_capture_arbiter_if.slave bus,
  input  logic                   stat_clr_i,
  output logic [CNT_W-1:0]       grant_cnt_a_o,
  output logic [CNT_W-1:0]       grant_cnt_b_o
);
  localparam int             BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0]  BURST_ONE = BW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_src_q,   out_src_d;
  logic             last_src_q,  last_src_d;
  logic [BW-1:0]    burst_q,     burst_d;
  logic [CNT_W-1:0] cnt_a_q,     cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q,     cnt_b_d;

  logic slot_free, gnt_a, gnt_b;

  // Grant decision. Gated by rst_ni so no ready leaks out during reset.
  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    slot_free = !out_valid_q || bus.out_ready;
    if (rst_ni && slot_free) begin
      if (bus.a_valid && bus.b_valid) begin
        // Stay with last_src until its burst is used up, then hand over.
        if (burst_q < BURST_MAX) begin
          gnt_b = last_src_q;
          gnt_a = !last_src_q;
        end else begin
          gnt_b = !last_src_q;
          gnt_a = last_src_q;
        end
      end else begin
        gnt_a = bus.a_valid;
        gnt_b = bus.b_valid;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    last_src_d  = last_src_q;
    burst_d     = burst_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;

    if (gnt_a || gnt_b) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_b ? bus.b_data : bus.a_data;
      out_src_d   = gnt_b;
      if (gnt_b == last_src_q) begin
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_ONE;
      end else begin
        last_src_d = gnt_b;
        burst_d    = BURST_ONE;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;   // drained with nothing to refill
    end

    if (stat_clr_i) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      if (gnt_a && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + 1'b1;
      if (gnt_b && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + 1'b1;
    end
  end

  // Reset leaves last_src = B with a spent burst so the first contention
  // goes to A.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      last_src_q  <= 1'b1;
      burst_q     <= BURST_MAX;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      last_src_q  <= last_src_d;
      burst_q     <= burst_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
    end
  end

  assign bus.a_ready   = gnt_a;
  assign bus.b_ready   = gnt_b;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign grant_cnt_a_o = cnt_a_q;
  assign grant_cnt_b_o = cnt_b_q;
endmodule

// File: tb/tb_input_capture_arbiter.sv
// Directed bench: three arbiters share one stimulus stream.
//   dut_d : defaults (MAX_BURST=2, CNT_W=8)
//   dut_r : MAX_BURST=1 (pure round-robin)
//   dut_s : CNT_W=2 (counter saturation)
module tb_input_capture_arbiter;
  logic clk = 1'b0;
  logic rst_n, a_valid, b_valid, a_data, b_data, out_ready, stat_clr;
  logic [7:0] cnt_a_d, cnt_b_d, cnt_a_r, cnt_b_r;
  logic [1:0] cnt_a_s, cnt_b_s;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_capture_arbiter_if #(.WIDTH(1)) if_d ();
  input_capture_arbiter_if #(.WIDTH(1)) if_r ();
  input_capture_arbiter_if #(.WIDTH(1)) if_s ();

  assign if_d.a_valid = a_valid;  assign if_d.a_data = a_data;
  assign if_d.b_valid = b_valid;  assign if_d.b_data = b_data;
  assign if_d.out_ready = out_ready;
  assign if_r.a_valid = a_valid;  assign if_r.a_data = a_data;
  assign if_r.b_valid = b_valid;  assign if_r.b_data = b_data;
  assign if_r.out_ready = out_ready;
  assign if_s.a_valid = a_valid;  assign if_s.a_data = a_data;
  assign if_s.b_valid = b_valid;  assign if_s.b_data = b_data;
  assign if_s.out_ready = out_ready;

  input_capture_arbiter #(.WIDTH(1), .MAX_BURST(2), .CNT_W(8)) dut_d (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_d.slave), .stat_clr_i(stat_clr),
    .grant_cnt_a_o(cnt_a_d), .grant_cnt_b_o(cnt_b_d));
  input_capture_arbiter #(.WIDTH(1), .MAX_BURST(1), .CNT_W(8)) dut_r (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_r.slave), .stat_clr_i(stat_clr),
    .grant_cnt_a_o(cnt_a_r), .grant_cnt_b_o(cnt_b_r));
  input_capture_arbiter #(.WIDTH(1), .MAX_BURST(2), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_s.slave), .stat_clr_i(stat_clr),
    .grant_cnt_a_o(cnt_a_s), .grant_cnt_b_o(cnt_b_s));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected out_src per contention cycle: 0 = A, 1 = B
  logic [5:0] exp_src_d, exp_src_r;
  logic [4:0] stream;

  initial begin
    exp_src_d = 6'b001100;  // bit i = cycle i : A,A,B,B,A,A
    exp_src_r = 6'b101010;  // A,B,A,B,A,B
    stream    = 5'b01010;   // bit i : 0,1,0,1,0

    // reset with traffic active
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 1'b1; b_data = 1'b0;
    out_ready = 1'b1; stat_clr = 1'b0;
    tick();
    chk("rst_out_valid", if_d.out_valid, 0);
    chk("rst_out_data",  if_d.out_data,  0);
    chk("rst_out_src",   if_d.out_src,   0);
    chk("rst_cnt_a",     cnt_a_d, 0);
    chk("rst_cnt_b",     cnt_b_d, 0);
    chk("rst_a_ready",   if_d.a_ready, 0);
    chk("rst_b_ready",   if_d.b_ready, 0);
    chk("rst_r_valid",   if_r.out_valid, 0);

    // release with both valid: first contention goes to A
    rst_n = 1'b1;
    #1;
    chk("first_a_ready", if_d.a_ready, 1);
    chk("first_b_ready", if_d.b_ready, 0);
    chk("first_r_a_ready", if_r.a_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("burst2_src%0d", i), if_d.out_src, exp_src_d[i]);
      chk($sformatf("rr_src%0d", i),     if_r.out_src, exp_src_r[i]);
      chk($sformatf("burst2_valid%0d", i), if_d.out_valid, 1);
    end
    chk("cont_cnt_a_d", cnt_a_d, 4);
    chk("cont_cnt_b_d", cnt_b_d, 2);
    chk("cont_cnt_a_r", cnt_a_r, 3);
    chk("cont_cnt_b_r", cnt_b_r, 3);
    chk("cont_cnt_a_s", cnt_a_s, 3);

    // idle cycle with counter clear: output drains, data holds
    a_valid = 1'b0; b_valid = 1'b0; stat_clr = 1'b1;
    #1;
    chk("idle_a_ready", if_d.a_ready, 0);
    chk("idle_b_ready", if_d.b_ready, 0);
    tick();
    stat_clr = 1'b0;
    chk("clr_cnt_a", cnt_a_d, 0);
    chk("clr_cnt_b", cnt_b_d, 0);
    chk("drain_valid", if_d.out_valid, 0);
    chk("drain_data_hold", if_d.out_data, 1);

    // A alone streaming 0,1,0,1,0
    a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = stream[i];
      #1;
      chk($sformatf("strm_b_ready%0d", i), if_d.b_ready, 0);
      tick();
      chk($sformatf("strm_data%0d", i), if_d.out_data, stream[i]);
      chk($sformatf("strm_src%0d", i),  if_d.out_src, 0);
      if (i == 3) chk("strm_cnt_a4", cnt_a_d, 4);
    end
    chk("strm_cnt_a5", cnt_a_d, 5);
    chk("sat_cnt_a",   cnt_a_s, 3);

    // clear in the same cycle as a grant
    a_data = 1'b1; stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clrgnt_cnt_a", cnt_a_d, 0);
    chk("clrgnt_cnt_s", cnt_a_s, 0);
    chk("clrgnt_data",  if_d.out_data, 1);

    // backpressure for 3 cycles with both requesting
    out_ready = 1'b0; b_valid = 1'b1; a_data = 1'b0; b_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_a_ready%0d", i), if_d.a_ready, 0);
      chk($sformatf("bp_b_ready%0d", i), if_d.b_ready, 0);
      tick();
      chk($sformatf("bp_valid%0d", i), if_d.out_valid, 1);
      chk($sformatf("bp_data%0d", i),  if_d.out_data, 1);
      chk($sformatf("bp_src%0d", i),   if_d.out_src, 0);
    end
    chk("bp_cnt_a", cnt_a_d, 0);

    // drain and refill in the same cycle
    out_ready = 1'b1; b_valid = 1'b0;
    #1;
    chk("refill_a_ready", if_d.a_ready, 1);
    tick();
    chk("refill_valid", if_d.out_valid, 1);
    chk("refill_data",  if_d.out_data, 0);
    chk("refill_cnt_a", cnt_a_d, 1);

    // mid-burst reset: A burst is spent so B wins, then reset restarts at A
    a_valid = 1'b1; b_valid = 1'b1; a_data = 1'b1; b_data = 1'b0;
    tick();
    chk("pre_rst_src", if_d.out_src, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_ready", if_d.a_ready, 0);
    chk("mid_rst_b_ready", if_d.b_ready, 0);
    tick();
    chk("mid_rst_valid", if_d.out_valid, 0);
    chk("mid_rst_data",  if_d.out_data, 0);
    chk("mid_rst_cnt_a", cnt_a_d, 0);
    chk("mid_rst_cnt_b", cnt_b_d, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_src0",  if_d.out_src, 0);
    chk("post_rst_data0", if_d.out_data, 1);
    tick();
    chk("post_rst_src1",  if_d.out_src, 0);
    tick();
    chk("post_rst_src2",  if_d.out_src, 1);
    chk("post_rst_cnt_a", cnt_a_d, 2);
    chk("post_rst_cnt_b", cnt_b_d, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/input_capture_arbiter.md
# input_capture_arbiter

Two-requester arbiter that shares one registered capture stage between the pin-pair operand source (A) and the port-pair operand source (B) of the input-delay benchmark datapath. A burst-limited round-robin policy grants one source per cycle into a single output register with valid/ready backpressure. Saturating per-source grant counters give the bench observable activity on every capture path. Single clock domain; all logic sits behind the input ports whose delays the benchmark constrains.

## Interface
- WIDTH, 1, data width of each source and of out_data
- MAX_BURST, 2, max consecutive grants to one source while the other is waiting (1 = pure round-robin); legal range 1..15
- CNT_W, 8, width of each grant counter
- clk  in  1  sole clock; all state updates on posedge clk
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- a_valid  in  1  source A (pin group) has data
- a_data  in  WIDTH  source A payload
- a_ready  out  1  A transfers this cycle (combinational grant)
- b_valid  in  1  source B (port group) has data
- b_data  in  WIDTH  source B payload
- b_ready  out  1  B transfers this cycle
- out_valid  out  1  output register holds data
- out_data  out  WIDTH  captured payload
- out_src  out  1  source of out_data: 0 = A, 1 = B
- out_ready  in  1  consumer accepts out_data
- stat_clr  in  1  synchronous clear of both grant counters
- grant_cnt_a  out  CNT_W  saturating count of A grants
- grant_cnt_b  out  CNT_W  saturating count of B grants

## Operation
- slot_free = !out_valid | out_ready. When slot_free = 0: a_ready = b_ready = 0, no state changes except counter clear.
- Grant when slot_free = 1:
  - only a_valid: grant A; only b_valid: grant B; neither: no grant.
  - both: if burst_cnt < MAX_BURST, grant last_src; otherwise grant the other source.
- Internal state: last_src (1 bit), burst_cnt ($clog2(MAX_BURST+1) bits).
  - Grant to last_src: burst_cnt <= min(burst_cnt+1, MAX_BURST).
  - Grant to the other source: last_src <= that source, burst_cnt <= 1.
  - No grant: both hold.
- Output register:
  - On a grant: out_valid <= 1, out_data <= the granted data, out_src <= the granted id.
  - No grant and out_ready = 1: out_valid <= 0; out_data and out_src hold.
  - No grant and out_ready = 0: all hold.
- Counters:
  - stat_clr = 1 forces both counters to 0. It takes priority over increments in the same cycle.
  - Otherwise, a grant increments the matching counter, saturating at 2^CNT_W-1.
- a_ready and b_ready are never both 1. A ready is never asserted while its valid is 0.

## Timing
- Reset (rst_n = 0 at posedge) gives:
  - out_valid = 0, out_data = 0, out_src = 0
  - grant_cnt_a = grant_cnt_b = 0
  - last_src = 1 (B), burst_cnt = MAX_BURST, so the first contention goes to A.
- Reset overrides any in-flight grant, drain or clear in the same cycle.
- a_ready and b_ready stay 0 during reset.
- Latency is 1 cycle: data granted at edge N appears on out_data after edge N.
- Throughput: 1 transfer per cycle when out_ready is held at 1, including a simultaneous drain and refill.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_src are stable and no ready is asserted.
- Counter values are visible 1 cycle after the grant.

## Test plan
- Reset: drive rst_n = 0 with traffic active -> next cycle out_valid = 0, counters 0, readies 0. Release with both valid -> first grant goes to A.
- A alone streaming 0,1,0,1 (WIDTH = 1) with out_ready = 1 -> out_data 0,1,0,1 one cycle later, out_src = 0 throughout, grant_cnt_a = 4.
- Both valid continuously, MAX_BURST = 2, out_ready = 1 -> out_src sequence A,A,B,B,A,A. With MAX_BURST = 1 -> A,B,A,B.
- out_ready = 0 for 3 cycles with out_valid = 1 -> a_ready = b_ready = 0, out_data unchanged. Raise out_ready with a_valid = 1 -> drain and refill in the same cycle, out_valid stays 1.
- CNT_W = 2, 5 A grants -> grant_cnt_a stops at 3. Assert stat_clr in the same cycle as a grant -> counter reads 0 next cycle.
- Pulse rst_n low for 1 cycle mid-burst -> output and counters cleared, and the arbitration order restarts with A.
